// File: rtl/truth_table_sweeper.sv
// Sweeps all 8 input rows of a 3-input circuit and captures its
// truth table, comparing the result with an expected code.
module truth_table_sweeper #(
  parameter int unsigned SETTLE   = 4,
  parameter logic [7:0]  EXPECTED = 8'h09
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code,
  output logic       match
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(SETTLE - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] row;
  logic [7:0] cnt;
  logic [7:0] work;
  logic [7:0] work_nx;

  // next-state decode; abort only matters while sweeping
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && !abort)
          state_nx = DRIVE;
      end
      DRIVE: begin
        if (abort)
          state_nx = IDLE;
        else if (cnt == LAST)
          state_nx = SAMPLE;
      end
      SAMPLE: begin
        if (abort)
          state_nx = IDLE;
        else if (row == 3'd7)
          state_nx = DONE;
        else
          state_nx = DRIVE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // working register with the current row's sample merged in
  always_comb begin
    work_nx = work;
    work_nx[3'd7 - row] = dut_out;
  end

  // state, row/settle counters and captured results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= 3'd0;
      cnt        <= 8'd0;
      work       <= 8'd0;
      table_code <= 8'd0;
      match      <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (state_nx == DRIVE) begin
            row  <= 3'd0;
            cnt  <= 8'd0;
            work <= 8'd0;
          end
        end
        DRIVE: cnt <= cnt + 8'd1;
        SAMPLE: begin
          if (!abort) begin
            work <= work_nx;
            cnt  <= 8'd0;
            if (row != 3'd7) begin
              row <= row + 3'd1;
            end else begin
              table_code <= work_nx;
              match      <= (work_nx == EXPECTED);
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs decoded from state
  always_comb begin
    busy = (state == DRIVE) || (state == SAMPLE);
    done = (state == DONE);
    {in1, in2, in3} = busy ? row : 3'd0;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table vectors, random sweeps
// against a row/latency model, and a SETTLE=1 instance.
module tb_truth_table_sweeper;

  localparam int S = 4;
  localparam int L = 8 * (S + 1) + 1;
  localparam logic [7:0] EXP = 8'h09;

  typedef enum int {NONE, ABORT, RESET, ABORT_DONE} act_t;

  typedef struct {
    logic [7:0] f;
    act_t       act;
    int         at;
    bit         hold;
    logic [7:0] exp_code;
    logic       exp_match;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in1, in2, in3, busy, done, match;
  logic [7:0] table_code;
  logic [7:0] fcode = 8'h00;
  logic [2:0] rowv;
  logic dut_out;

  logic start1 = 1'b0;
  logic a1, a2, a3, b1, d1, m1;
  logic [7:0] tc1;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mcode = 8'h00;
  logic mmatch = 1'b0;

  assign rowv = {in1, in2, in3};
  assign dut_out = fcode[3'd7 - rowv];

  truth_table_sweeper #(.SETTLE(S), .EXPECTED(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_out(dut_out), .in1(in1), .in2(in2), .in3(in3),
    .busy(busy), .done(done), .table_code(table_code),
    .match(match)
  );

  truth_table_sweeper #(.SETTLE(1), .EXPECTED(EXP)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .dut_out(1'b1), .in1(a1), .in2(a2), .in3(a3),
    .busy(b1), .done(d1), .table_code(tc1), .match(m1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One sweep; row n of the model is (n-1)/(S+1), done at cycle L.
  task automatic sweep(input logic [7:0] f, input act_t act,
                       input int at, input bit hold);
    fcode = f;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int n = 1; n < L; n++) begin
      check("drive", {busy, done, in1, in2, in3},
            {2'b10, 3'((n - 1) / (S + 1))});
      if (act == ABORT && n == at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort", {busy, done, in1, in2, in3}, 0);
        check("abort_keep", {match, table_code}, {mmatch, mcode});
        return;
      end
      if (act == RESET && n == at) begin
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        mcode = 8'h00;
        mmatch = 1'b0;
        check("rst_mid", {busy, done, in1, in2, in3, match,
                          table_code}, 0);
        return;
      end
      tick();
    end
    mcode = f;
    mmatch = (f == EXP);
    check("done", {busy, done, in1, in2, in3}, 5'b01000);
    check("code", {match, table_code}, {mmatch, mcode});
    if (act == ABORT_DONE) abort = 1'b1;
    tick();
    abort = 1'b0;
    start = hold;
    check("idle", {busy, done, in1, in2, in3}, 0);
    check("keep", {match, table_code}, {mmatch, mcode});
  endtask

  vec_t tbl[12];

  initial begin
    int n;
    int r;
    tbl[0]  = '{8'h09, NONE, 0, 1'b0, 8'h09, 1'b1};
    tbl[1]  = '{8'hF0, NONE, 0, 1'b0, 8'hF0, 1'b0};
    tbl[2]  = '{8'h09, NONE, 0, 1'b0, 8'h09, 1'b1};
    tbl[3]  = '{8'hA5, ABORT, 20, 1'b0, 8'h09, 1'b1};
    tbl[4]  = '{8'h3C, RESET, 10, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{8'h09, NONE, 0, 1'b0, 8'h09, 1'b1};
    tbl[6]  = '{8'h66, ABORT, 5, 1'b0, 8'h09, 1'b1};
    tbl[7]  = '{8'hFF, ABORT, 1, 1'b0, 8'h09, 1'b1};
    tbl[8]  = '{8'hC3, ABORT_DONE, 0, 1'b0, 8'hC3, 1'b0};
    tbl[9]  = '{8'h09, NONE, 0, 1'b1, 8'h09, 1'b1};
    tbl[10] = '{8'h81, NONE, 0, 1'b1, 8'h81, 1'b0};
    tbl[11] = '{8'h5A, NONE, 0, 1'b0, 8'h5A, 1'b0};

    rst_n = 1'b0;
    tick();
    tick();
    check("reset", {busy, done, in1, in2, in3, match,
                    table_code}, 0);
    rst_n = 1'b1;
    tick();
    check("post_reset", {busy, done, in1, in2, in3}, 0);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort", {busy, done}, 0);
    tick();
    check("start_abort2", {busy, done}, 0);

    foreach (tbl[i]) begin
      sweep(tbl[i].f, tbl[i].act, tbl[i].at, tbl[i].hold);
      check("tbl_code", {match, table_code},
            {tbl[i].exp_match, tbl[i].exp_code});
    end

    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 9);
      sweep(8'($urandom),
            r < 6 ? NONE : r < 8 ? ABORT : r < 9 ? RESET : ABORT_DONE,
            $urandom_range(1, L - 1), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    tick();

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    while (!d1 && n < 100) begin
      tick();
      n++;
    end
    check("s1_latency", n, 17);
    check("s1_code", tc1, 8'hFF);
    check("s1_match", m1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have a parameter SETTLE, default 4: the number of cycles the inputs are held before the output is sampled; legal range 1..255.
REQ-002 The block SHALL have a parameter EXPECTED, default 8'h09: the 8-bit truth-table code the captured result is compared against.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request one sweep; sampled only in IDLE.
REQ-007 abort  input  1  terminate a sweep in progress.
REQ-008 dut_out  input  1  output of the 3-input logic circuit under characterisation.
REQ-009 in1  output  1  drive to the circuit; MSB of the row index.
REQ-010 in2  output  1  drive to the circuit; middle bit of the row index.
REQ-011 in3  output  1  drive to the circuit; LSB of the row index.
REQ-012 busy  output  1  high in the DRIVE and SAMPLE states.
REQ-013 done  output  1  one-cycle pulse when a sweep completes.
REQ-014 table_code  output  8  last completed truth-table code.
REQ-015 match  output  1  table_code equals EXPECTED; valid after the first completed sweep.

Function
REQ-016 The block SHALL implement the states IDLE, DRIVE, SAMPLE and DONE.
REQ-017 In IDLE with start=1 and abort=0, the block SHALL move to DRIVE next cycle with row=0 and settle counter=0.
REQ-018 In IDLE with start=1 and abort=1 in the same cycle, the block SHALL remain in IDLE.
REQ-019 In DRIVE, {in1,in2,in3} SHALL equal the row index, a 3-bit value 0..7.
REQ-020 The DRIVE state SHALL last exactly SETTLE cycles, with the counter running 0..SETTLE-1, then move to SAMPLE.
REQ-021 In SAMPLE, inputs SHALL keep the row value, and dut_out SHALL be written into working-register bit (7-row).
REQ-022 The bit mapping SHALL be: row 3'b000 into bit 7, row 3'b111 into bit 0.
REQ-023 After SAMPLE, if row<7 the block SHALL increment row, clear the counter and re-enter DRIVE; if row=7 it SHALL go to DONE.
REQ-024 In DONE, table_code and match SHALL take the working register and its comparison in the same cycle, done=1 for that cycle, and the next state SHALL be IDLE.
REQ-025 Latency: with start accepted at edge t, done SHALL be high in cycle t+1+8*(SETTLE+1), so SETTLE=4 gives 41 cycles.
REQ-026 start while busy or in DONE SHALL be ignored and not queued.
REQ-027 abort in DRIVE or SAMPLE SHALL return the block to IDLE next cycle with no done pulse; table_code and match SHALL keep their prior values.
REQ-028 abort in DONE SHALL have no effect; the completion SHALL stand.
REQ-029 In IDLE and DONE, in1, in2 and in3 SHALL be 0.
REQ-030 Rows SHALL never wrap: after row 7 the sweep ends, and row is reset to 0 on the next start.

Reset
REQ-031 When rst_n=0 at a clock edge, next cycle the block SHALL be in IDLE with in1/in2/in3=0, busy=0, done=0, table_code=8'h00, match=0, and row, counter and working register all 0.
REQ-032 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse and SHALL clear table_code.
REQ-033 Reset SHALL take priority over start and abort.

Verification
REQ-034 dut_out modelled as the 0x09 function (high for rows 100 and 111), start pulse, SETTLE=4 -> done at cycle 41, table_code=8'h09, match=1.
REQ-035 dut_out=~in1 -> table_code=8'hF0, match=0; {in1,in2,in3} steps 0..7, each value held 5 cycles.
REQ-036 Sweep producing 8'h09, then abort at cycle 20 of a second sweep -> no done, busy falls next cycle, table_code stays 8'h09, match stays 1.
REQ-037 start held high continuously -> back-to-back sweeps with exactly one IDLE cycle between done and the next DRIVE; no start accepted while busy.
REQ-038 rst_n=0 at cycle 10 of a sweep -> all outputs at reset values next cycle; a fresh start then completes normally at 41 cycles.
REQ-039 SETTLE=1 with dut_out constant 1 -> done at cycle 17, table_code=8'hFF.
